// File: rtl/axi4_lite_csr_pkg.sv
// Shared types and address decode for the AXI4-Lite CSR bank.
// Combinational only; no latency.
// No flow control here; used by both read and write paths.
package axi4_lite_csr_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  // Decode result is sized for the largest supported bank (256 registers).
  localparam int unsigned MAX_IDX_W = 8;
  localparam int unsigned MAX_REGS  = 256;

  typedef struct packed {
    logic [MAX_IDX_W-1:0] idx;
    logic                 oob;
    logic                 ro;
  } decode_t;

  function automatic int unsigned idx_w(input int unsigned nregs);
    return (nregs < 2) ? 1 : $clog2(nregs);
  endfunction

  // Word index from the byte address; the low two address bits are ignored.
  function automatic decode_t decode(input logic [31:0] addr, input int unsigned nregs,
                                     input logic [MAX_REGS-1:0] ro_mask);
    decode_t     d;
    logic [29:0] word;
    word  = 30'(addr >> 2);
    d.oob = (word >= 30'(nregs));
    d.idx = MAX_IDX_W'(word & 30'(nregs - 1));
    d.ro  = ro_mask[d.idx];
    return d;
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle with slave and master views.
// No logic, no latency.
// Handshakes are plain valid/ready per channel.
interface axi4_lite_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport s (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport m (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_capture_slot.sv
// One-deep holding register for an AXI channel beat, emptied by a take strobe.
// Captured beat is visible on the cycle after the input handshake.
// in_rdy is low while full; a take frees the slot for the following cycle.
module axi4_lite_capture_slot #(
  parameter int W = 32
) (
  input  logic         bar_clk,
  input  logic         bar_aresetn,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         take
);

  logic         full_q, full_d;
  logic [W-1:0] dat_q, dat_d;

  assign in_rdy  = ~full_q;
  assign out_vld = full_q;
  assign out_dat = dat_q;

  // Fill on handshake, empty on take; take only happens while full so the two never collide.
  always_comb begin
    full_d = full_q;
    dat_d  = dat_q;
    if (take) full_d = 1'b0;
    if (in_vld && in_rdy) begin
      full_d = 1'b1;
      dat_d  = in_dat;
    end
  end

  // Slot state register.
  always_ff @(posedge bar_clk or negedge bar_aresetn) begin
    if (!bar_aresetn) begin
      full_q <= 1'b0;
      dat_q  <= '0;
    end else begin
      full_q <= full_d;
      dat_q  <= dat_d;
    end
  end

endmodule

// File: rtl/axi4_lite_csr_bank.sv
// AXI4-Lite register bank: NREGS x 32-bit RW/RO words plus per-register access strobes.
// Write response one cycle after the later of AW/W capture; read data the cycle after AR.
// AW/W stall while their slot is full; commit waits for the B channel; AR stalls while R is held.
module axi4_lite_csr_bank
  import axi4_lite_csr_pkg::*;
#(
  parameter int unsigned      NREGS    = 16,
  parameter logic [31:0]      ID_VALUE = 32'h00FB_0001,
  parameter logic [NREGS-1:0] RO_MASK  = NREGS'(1)
) (
  input  logic                   bar_clk,
  input  logic                   bar_aresetn,
  axi4_lite_if.s                 s,
  output logic [NREGS-1:0][31:0] reg_out,
  input  logic [NREGS-1:0][31:0] reg_in,
  output logic [NREGS-1:0]       wr_pulse,
  output logic [NREGS-1:0]       rd_pulse
);

  localparam int unsigned        IW       = idx_w(NREGS);
  // Register 0 holds the ID and is always read-only.
  localparam logic [NREGS-1:0]   RO_EFF   = RO_MASK | NREGS'(1);
  localparam logic [MAX_REGS-1:0] RO_EFF_W = MAX_REGS'(RO_EFF);

  logic                   aw_vld, w_vld, commit, ar_hs;
  logic [31:0]            aw_dat;
  logic [35:0]            w_dat;
  logic [3:0]             w_strb;
  logic [31:0]            w_data;
  decode_t                wr_dec, rd_dec;
  logic [IW-1:0]          wr_idx, rd_idx;

  logic [NREGS-1:0][31:0] regs_q, regs_d;
  logic                   bvalid_q, bvalid_d;
  resp_t                  bresp_q, bresp_d;
  logic                   rvalid_q, rvalid_d;
  resp_t                  rresp_q, rresp_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [NREGS-1:0]       wr_pulse_q, wr_pulse_d, rd_pulse_q, rd_pulse_d;
  logic                   unused_ok;

  axi4_lite_capture_slot #(.W(32)) u_aw_slot (
    .bar_clk, .bar_aresetn,
    .in_vld (s.awvalid), .in_rdy (s.awready), .in_dat (s.awaddr),
    .out_vld(aw_vld),    .out_dat(aw_dat),    .take   (commit)
  );

  axi4_lite_capture_slot #(.W(36)) u_w_slot (
    .bar_clk, .bar_aresetn,
    .in_vld (s.wvalid), .in_rdy (s.wready), .in_dat ({s.wstrb, s.wdata}),
    .out_vld(w_vld),    .out_dat(w_dat),    .take   (commit)
  );

  assign w_strb = w_dat[35:32];
  assign w_data = w_dat[31:0];
  assign wr_dec = decode(aw_dat, NREGS, RO_EFF_W);
  assign rd_dec = decode(s.araddr, NREGS, RO_EFF_W);
  assign wr_idx = wr_dec.idx[IW-1:0];
  assign rd_idx = rd_dec.idx[IW-1:0];

  // A held B response blocks the next commit unless it is being accepted this cycle.
  assign commit = aw_vld & w_vld & (~bvalid_q | s.bready);
  assign ar_hs  = s.arvalid & ~rvalid_q;

  assign s.bvalid  = bvalid_q;
  assign s.bresp   = bresp_q;
  assign s.arready = ~rvalid_q;
  assign s.rvalid  = rvalid_q;
  assign s.rresp   = rresp_q;
  assign s.rdata   = rdata_q;
  assign wr_pulse  = wr_pulse_q;
  assign rd_pulse  = rd_pulse_q;

  assign unused_ok = ^{s.awprot, s.arprot, wr_dec.idx, rd_dec.idx};

  // Read-only entries expose zero; their contents come from reg_in on reads instead.
  always_comb begin
    reg_out = '0;
    for (int i = 0; i < int'(NREGS); i++) reg_out[i] = RO_EFF[i] ? 32'h0 : regs_q[i];
  end

  // Write commit: classify the address, merge enabled bytes, raise the B response and strobe.
  always_comb begin
    regs_d     = regs_q;
    bvalid_d   = bvalid_q & ~s.bready;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    if (commit) begin
      bvalid_d = 1'b1;
      if (wr_dec.oob) begin
        bresp_d = RESP_DECERR;
      end else if (wr_dec.ro) begin
        bresp_d = RESP_SLVERR;
      end else begin
        bresp_d            = RESP_OKAY;
        wr_pulse_d[wr_idx] = 1'b1;
        for (int b = 0; b < 4; b++) begin
          if (w_strb[b]) regs_d[wr_idx][8*b +: 8] = w_data[8*b +: 8];
        end
      end
    end
  end

  // Read accept: data is taken from the pre-commit register state, so a same-cycle write is not seen.
  always_comb begin
    rvalid_d   = rvalid_q & ~s.rready;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    rd_pulse_d = '0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (rd_dec.oob) begin
        rresp_d = RESP_DECERR;
        rdata_d = 32'h0;
      end else begin
        rresp_d            = RESP_OKAY;
        rd_pulse_d[rd_idx] = 1'b1;
        if (rd_idx == '0)   rdata_d = ID_VALUE;
        else if (rd_dec.ro) rdata_d = reg_in[rd_idx];
        else                rdata_d = regs_q[rd_idx];
      end
    end
  end

  // Register array and write-response state.
  always_ff @(posedge bar_clk or negedge bar_aresetn) begin
    if (!bar_aresetn) begin
      regs_q     <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      regs_q     <= regs_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // Read-response state.
  always_ff @(posedge bar_clk or negedge bar_aresetn) begin
    if (!bar_aresetn) begin
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      rd_pulse_q <= '0;
    end else begin
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      rd_pulse_q <= rd_pulse_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_csr_bank.sv
// Randomized and directed bench for the CSR bank against an array-based register model.
// Bus driven 1 time unit after posedge, sampled at negedge.
// Exercises B-channel backpressure and asynchronous reset during a held read.
module tb_axi4_lite_csr_bank;

  localparam logic [31:0] ID = 32'h00FB_0001;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi4_lite_if #(.DW(32), .AW(32)) bus ();

  logic [15:0][31:0] reg_out;
  logic [15:0][31:0] reg_in;
  logic [15:0]       wr_pulse, rd_pulse;

  axi4_lite_csr_bank #(.NREGS(16), .ID_VALUE(ID), .RO_MASK(16'hC001)) dut (
    .bar_clk(clk), .bar_aresetn(rstn), .s(bus),
    .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain register array plus the set of read-only indices.
  logic [15:0][31:0] mdl;
  logic [15:0]       ro_m;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % 32'd16);
  endfunction

  function automatic logic [1:0] exp_resp_wr(input logic [31:0] a);
    if (a >= 32'd64) return 2'b11;
    if (ro_m[idx_of(a)]) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    if (a >= 32'd64) return 32'h0;
    if (idx_of(a) == 0) return ID;
    if (ro_m[idx_of(a)]) return reg_in[idx_of(a)];
    return mdl[idx_of(a)];
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    if (exp_resp_wr(a) == 2'b00)
      for (int b = 0; b < 4; b++) if (st[b]) mdl[idx_of(a)][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                          output logic [1:0] resp, output logic [15:0] pls);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int n = 0;
    resp = 'x; pls = '0;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = st;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge clk);
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      @(posedge clk); #1;
      if (aw_hs) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  bus.wvalid = 1'b0; end
      n++;
    end
    n = 0;
    forever begin
      @(negedge clk);
      pls |= wr_pulse;
      if (bus.bvalid) break;
      if (++n > 20) begin
        vectors++; miscompares++;
        $display("FAIL write_timeout: no bvalid for addr %h", a);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        return;
      end
    end
    resp = bus.bresp;
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output logic [15:0] pls);
    bit hs;
    int n = 0;
    d = 'x; resp = 'x; pls = '0;
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
    do begin
      @(negedge clk); hs = bus.arready;
      @(posedge clk); #1; n++;
    end while (!hs && n < 20);
    bus.arvalid = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      pls |= rd_pulse;
      if (bus.rvalid) break;
      if (++n > 20) begin
        vectors++; miscompares++;
        $display("FAIL read_timeout: no rvalid for addr %h", a);
        return;
      end
    end
    d = bus.rdata; resp = bus.rresp;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; logic [15:0] p;
    repeat (3) @(negedge clk);
    vectors++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin miscompares++; $display("FAIL reset_readys: got %b want 111", {bus.awready, bus.wready, bus.arready}); end
    vectors++; if ({bus.bvalid, bus.rvalid, bus.bresp, bus.rresp} !== 6'b0) begin miscompares++; $display("FAIL reset_resp: got %b want 0", {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp}); end
    vectors++; if (bus.rdata !== 32'h0 || reg_out !== '0) begin miscompares++; $display("FAIL reset_data: rdata %h reg_out %h want 0", bus.rdata, reg_out); end
    vectors++; if ({wr_pulse, rd_pulse} !== 32'h0) begin miscompares++; $display("FAIL reset_pulses: got %h want 0", {wr_pulse, rd_pulse}); end
    rstn = 1'b1;
    @(posedge clk); #1;
    do_read(32'h00, d, r, p);
    vectors++; if (d !== ID || r !== 2'b00) begin miscompares++; $display("FAIL reset_id_read: got %h/%b want %h/00", d, r, ID); end
    vectors++; if (p !== 16'h0001) begin miscompares++; $display("FAIL reset_id_rdpulse: got %h want 0001", p); end
    do_read(32'h04, d, r, p);
    vectors++; if (d !== 32'h0 || r !== 2'b00) begin miscompares++; $display("FAIL reset_reg1_read: got %h/%b want 0/00", d, r); end
  endtask

  task automatic test_skewed_write();
    bus.bready = 1'b1; bus.wdata = 32'h0000_00A5; bus.wstrb = 4'h1; bus.wvalid = 1'b1;
    @(posedge clk); #1 bus.wvalid = 1'b0;
    @(negedge clk);
    vectors++; if (bus.wready !== 1'b0 || bus.bvalid !== 1'b0) begin miscompares++; $display("FAIL skew_w_held: wready %b bvalid %b want 0 0", bus.wready, bus.bvalid); end
    @(posedge clk); @(posedge clk); #1;
    bus.awaddr = 32'h08; bus.awvalid = 1'b1;
    @(posedge clk); #1 bus.awvalid = 1'b0;
    @(negedge clk);
    vectors++; if (bus.bvalid !== 1'b0) begin miscompares++; $display("FAIL skew_bvalid_early: got %b want 0", bus.bvalid); end
    mdl_write(32'h08, 32'h0000_00A5, 4'h1);
    @(negedge clk);
    vectors++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin miscompares++; $display("FAIL skew_bresp: got %b/%b want 1/00", bus.bvalid, bus.bresp); end
    vectors++; if (wr_pulse !== 16'h0004 || reg_out !== mdl) begin miscompares++; $display("FAIL skew_commit: pulse %h reg2 %h want 0004 %h", wr_pulse, reg_out[2], mdl[2]); end
    @(negedge clk);
    vectors++; if (bus.bvalid !== 1'b0 || wr_pulse !== 16'h0) begin miscompares++; $display("FAIL skew_after: bvalid %b pulse %h want 0 0", bus.bvalid, wr_pulse); end
  endtask

  task automatic test_strobes_ro();
    logic [31:0] d; logic [1:0] r; logic [15:0] p;
    do_write(32'h08, 32'hDEAD_BEEF, 4'hC, r, p);
    mdl_write(32'h08, 32'hDEAD_BEEF, 4'hC);
    vectors++; if (r !== 2'b00 || p !== 16'h0004 || reg_out[2] !== 32'hDEAD_00A5) begin miscompares++; $display("FAIL strobe_merge: resp %b pulse %h reg2 %h want 00 0004 dead00a5", r, p, reg_out[2]); end
    do_write(32'h00, 32'h1234_5678, 4'hF, r, p);
    vectors++; if (r !== 2'b10 || p !== 16'h0) begin miscompares++; $display("FAIL ro_id_write: resp %b pulse %h want 10 0", r, p); end
    do_read(32'h00, d, r, p);
    vectors++; if (d !== ID) begin miscompares++; $display("FAIL ro_id_kept: got %h want %h", d, ID); end
    do_write(32'h0C, 32'hFFFF_FFFF, 4'h0, r, p);
    vectors++; if (r !== 2'b00 || p !== 16'h0008 || reg_out !== mdl) begin miscompares++; $display("FAIL zero_strobe: resp %b pulse %h want 00 0008", r, p); end
    reg_in[15] = $urandom;
    do_read(32'h3C, d, r, p);
    vectors++; if (d !== reg_in[15] || r !== 2'b00 || p !== 16'h8000) begin miscompares++; $display("FAIL ro_status_read: got %h/%b/%h want %h/00/8000", d, r, p, reg_in[15]); end
    do_write(32'h0F, 32'h5A5A_1234, 4'hF, r, p);
    mdl_write(32'h0F, 32'h5A5A_1234, 4'hF);
    vectors++; if (r !== 2'b00 || reg_out !== mdl) begin miscompares++; $display("FAIL low_addr_ignored: resp %b reg3 %h want 00 %h", r, reg_out[3], mdl[3]); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; logic [15:0] p;
    do_write(32'h40, 32'hCAFE_F00D, 4'hF, r, p);
    vectors++; if (r !== 2'b11 || p !== 16'h0 || reg_out !== mdl) begin miscompares++; $display("FAIL oob_write: resp %b pulse %h want 11 0", r, p); end
    do_read(32'h40, d, r, p);
    vectors++; if (d !== 32'h0 || r !== 2'b11 || p !== 16'h0) begin miscompares++; $display("FAIL oob_read: got %h/%b/%h want 0/11/0", d, r, p); end
  endtask

  task automatic test_backpressure();
    bus.bready = 1'b0;
    bus.awaddr = 32'h3C; bus.wdata = 32'h1111_1111; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(posedge clk); #1 bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(posedge clk); #1;
    bus.awaddr = 32'h14; bus.wdata = 32'h2222_3333; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(posedge clk); #1 bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b10 || bus.awready !== 1'b0 || bus.wready !== 1'b0 || wr_pulse !== 16'h0 || reg_out !== mdl) begin
        miscompares++;
        $display("FAIL bp_hold%0d: bvalid %b bresp %b awrdy %b wrdy %b pulse %h want 1 10 0 0 0", c, bus.bvalid, bus.bresp, bus.awready, bus.wready, wr_pulse);
      end
    end
    @(posedge clk); #1 bus.bready = 1'b1;
    @(negedge clk);
    vectors++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b10) begin miscompares++; $display("FAIL bp_first_resp: got %b/%b want 1/10", bus.bvalid, bus.bresp); end
    mdl_write(32'h14, 32'h2222_3333, 4'hF);
    @(negedge clk);
    vectors++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || wr_pulse !== 16'h0020 || reg_out !== mdl) begin miscompares++; $display("FAIL bp_second_commit: %b/%b pulse %h reg5 %h want 1/00 0020 %h", bus.bvalid, bus.bresp, wr_pulse, reg_out[5], mdl[5]); end
    @(negedge clk);
    vectors++; if (bus.bvalid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: bvalid %b want 0", bus.bvalid); end
  endtask

  task automatic test_random();
    logic [31:0] a, dat, d; logic [3:0] st; logic [1:0] r; logic [15:0] p;
    for (int k = 0; k < 60; k++) begin
      a = 32'($urandom_range(0, 79));
      if ($urandom_range(0, 9) == 0) a = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        dat = $urandom; st = 4'($urandom_range(0, 15));
        do_write(a, dat, st, r, p);
        mdl_write(a, dat, st);
        vectors++;
        if (r !== exp_resp_wr(a) || p !== ((exp_resp_wr(a) == 2'b00) ? 16'(1 << idx_of(a)) : 16'h0) || reg_out !== mdl) begin
          miscompares++;
          $display("FAIL rnd_write%0d addr %h: resp %b pulse %h want %b", k, a, r, p, exp_resp_wr(a));
        end
      end else begin
        for (int i = 0; i < 16; i++) reg_in[i] = $urandom;
        do_read(a, d, r, p);
        vectors++;
        if (d !== exp_rdata(a) || r !== ((a >= 32'd64) ? 2'b11 : 2'b00) || p !== ((a >= 32'd64) ? 16'h0 : 16'(1 << idx_of(a)))) begin
          miscompares++;
          $display("FAIL rnd_read%0d addr %h: got %h/%b/%h want %h", k, a, d, r, p, exp_rdata(a));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d; logic [1:0] r; logic [15:0] p;
    do_write(32'h08, 32'h7777_0001, 4'hF, r, p);
    mdl_write(32'h08, 32'h7777_0001, 4'hF);
    bus.rready = 1'b0; bus.araddr = 32'h08; bus.arvalid = 1'b1;
    @(posedge clk); #1 bus.arvalid = 1'b0;
    @(negedge clk);
    vectors++; if (bus.rvalid !== 1'b1 || bus.rdata !== mdl[2] || rd_pulse !== 16'h0004) begin miscompares++; $display("FAIL ar_latency: rvalid %b rdata %h pulse %h want 1 %h 0004", bus.rvalid, bus.rdata, rd_pulse, mdl[2]); end
    @(negedge clk);
    vectors++; if (bus.rvalid !== 1'b1 || bus.arready !== 1'b0 || rd_pulse !== 16'h0) begin miscompares++; $display("FAIL r_held: rvalid %b arready %b pulse %h want 1 0 0", bus.rvalid, bus.arready, rd_pulse); end
    #2 rstn = 1'b0;
    #1;
    vectors++; if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1 || reg_out !== '0) begin miscompares++; $display("FAIL async_reset: rvalid %b arready %b reg2 %h want 0 1 0", bus.rvalid, bus.arready, reg_out[2]); end
    mdl = '0;
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    do_read(32'h08, d, r, p);
    vectors++; if (d !== 32'h0 || r !== 2'b00) begin miscompares++; $display("FAIL post_reset_read: got %h/%b want 0/00", d, r); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mdl = '0; ro_m = 16'hC001;
    for (int i = 0; i < 16; i++) reg_in[i] = $urandom;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    test_reset();
    test_skewed_write();
    test_strobes_ro();
    test_out_of_range();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
